// File: rtl/ecc_pkg.sv
// ecc_pkg: shared helpers for the Hamming SEC (optionally SEC-DED) stream decoder.
// Holds the check-bit count derivation, the data-bit to code-position mapping
// and the per-bit syndrome masks used by the syndrome generator.
package ecc_pkg;

    // Widest supported data word and the check bits it needs
    localparam int MAX_DATA_W = 64;
    localparam int MAX_P      = 7;
    localparam int MAX_N      = MAX_DATA_W + MAX_P;

    // Smallest p with 2^p >= data_w + p + 1 (scanned downward so the smallest wins)
    function automatic int calc_p(input int data_w);
        int p;
        p = MAX_P;
        for (int c = MAX_P; c >= 1; c--) begin
            if ((32'sd1 << c) >= (data_w + c + 32'sd1)) begin
                p = c;
            end
        end
        return p;
    endfunction

    // True when a 1-based Hamming position holds a check bit
    function automatic bit is_pow2(input int v);
        return (v != 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

    // 0-based codeword index of data bit k (k-th non-power-of-two position)
    function automatic int data_pos(input int k);
        int cnt;
        int res;
        cnt = 32'sd0;
        res = 32'sd0;
        for (int pos = 1; pos <= MAX_N; pos++) begin
            if (!is_pow2(pos)) begin
                if (cnt == k) begin
                    res = pos - 32'sd1;
                end
                cnt = cnt + 32'sd1;
            end
        end
        return res;
    endfunction

    // Codeword indices that feed syndrome bit j: bit j of (index+1) is set
    function automatic logic [MAX_N-1:0] syn_mask(input int j);
        logic [MAX_N-1:0] m;
        for (int i = 0; i < MAX_N; i++) begin
            m[i] = ((((i + 32'sd1) >>> j) & 32'sd1) != 32'sd0);
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: combinational Hamming syndrome over the DATA_W+P
// Hamming-coded bits. Shared between encoder and decoder so both agree on
// the position layout; the encoder feeds zeros in the check positions.
module ecc_syndrome_calc
    import ecc_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int P = calc_p(DATA_W),
    localparam int N = DATA_W + P
) (
    input  logic [N-1:0] code,
    output logic [P-1:0] syndrome
);

    for (genvar j = 0; j < P; j++) begin : g_syn
        localparam logic [MAX_N-1:0] MASK = syn_mask(j);
        assign syndrome[j] = ^(code & MASK[N-1:0]);
    end

endmodule

// File: rtl/ecc_stream_decoder.sv
// ecc_stream_decoder: two-stage streaming Hamming decoder with valid/ready
// handshakes and saturating corrected/uncorrectable error counters.
// Optional feature macro: ECC_DED_EN adds an overall even-parity bit at
// in_code[CODE_W-1] and turns the decoder into SEC-DED.
// Stage 1 keeps only the data bits of the codeword; check bits are fully
// consumed by the syndrome computed in the same cycle.
module ecc_stream_decoder
    import ecc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int P = calc_p(DATA_W),
    localparam int N = DATA_W + P,
`ifdef ECC_DED_EN
    localparam int CODE_W = N + 1
`else
    localparam int CODE_W = N
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorr,
    output logic [P-1:0]      out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [P-1:0]     SYN_MAX = P'(N);

    logic              adv_s;
    logic              hs_s;
    logic [P-1:0]      syn_calc_s;
    logic [DATA_W-1:0] raw_data_s;
    logic [DATA_W-1:0] fixed_data_s;
    logic              in_range_s;
    logic              fix_s;
    logic              corr_s;
    logic              unc_s;

    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [P-1:0]      s1_syn_r;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_corr_r;
    logic              out_unc_r;
    logic [P-1:0]      out_syn_r;
    logic [CNT_W-1:0]  corr_cnt_r;
    logic [CNT_W-1:0]  uncorr_cnt_r;

`ifdef ECC_DED_EN
    logic pm_calc_s;
    logic s1_pm_r;
    assign pm_calc_s = ^in_code;
`endif

    // Both stages move together; a stalled output freezes the whole pipe
    assign adv_s    = !out_valid_r || out_ready;
    assign hs_s     = out_valid_r && out_ready;
    assign in_ready = adv_s;

    ecc_syndrome_calc #(
        .DATA_W   (DATA_W)
    ) u_syndrome (
        .code     (in_code[N-1:0]),
        .syndrome (syn_calc_s)
    );

    // Data bits are gathered from their Hamming positions; a data bit flips
    // only when the syndrome points exactly at its position
    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        localparam int           POS  = data_pos(k);
        localparam logic [P-1:0] HPOS = P'(POS + 1);
        assign raw_data_s[k]   = in_code[POS];
        assign fixed_data_s[k] = s1_data_r[k] ^ (fix_s && (s1_syn_r == HPOS));
    end

    // Stage 1: capture the raw data bits, syndrome and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_syn_r   <= '0;
`ifdef ECC_DED_EN
            s1_pm_r    <= 1'b0;
`endif
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            s1_data_r  <= raw_data_s;
            s1_syn_r   <= syn_calc_s;
`ifdef ECC_DED_EN
            s1_pm_r    <= pm_calc_s;
`endif
        end
    end

    // Classify the stage-1 word: clean, correctable or uncorrectable
    always_comb begin
        in_range_s = (s1_syn_r != '0) && (s1_syn_r <= SYN_MAX);
        fix_s      = 1'b0;
        corr_s     = 1'b0;
        unc_s      = 1'b0;
`ifdef ECC_DED_EN
        if (s1_pm_r) begin
            if (s1_syn_r == '0) begin
                // Only the overall parity bit flipped; data is already right
                corr_s = 1'b1;
            end else if (in_range_s) begin
                fix_s  = 1'b1;
                corr_s = 1'b1;
            end else begin
                unc_s  = 1'b1;
            end
        end else begin
            if (s1_syn_r != '0) begin
                // Even overall parity with a nonzero syndrome: double error
                unc_s = 1'b1;
            end else begin
                unc_s = 1'b0;
            end
        end
`else
        if (in_range_s) begin
            fix_s  = 1'b1;
            corr_s = 1'b1;
        end else if (s1_syn_r != '0) begin
            unc_s  = 1'b1;
        end else begin
            unc_s  = 1'b0;
        end
`endif
    end

    // Stage 2: register corrected data and flags; bubbles carry clear flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_corr_r  <= 1'b0;
            out_unc_r   <= 1'b0;
            out_syn_r   <= '0;
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            out_data_r  <= fixed_data_s;
            out_corr_r  <= s1_valid_r & corr_s;
            out_unc_r   <= s1_valid_r & unc_s;
            out_syn_r   <= s1_syn_r;
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (clr_cnt) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (hs_s) begin
            if (out_corr_r && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (out_unc_r && (uncorr_cnt_r != CNT_MAX)) begin
                uncorr_cnt_r <= uncorr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_corrected = out_corr_r;
    assign out_uncorr    = out_unc_r;
    assign out_syndrome  = out_syn_r;
    assign corr_cnt      = corr_cnt_r;
    assign uncorr_cnt    = uncorr_cnt_r;

endmodule

// File: doc/ecc_stream_decoder.md
ECC_STREAM_DECODER -- requirements
Module: ecc_stream_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, protected data width (4..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of each error counter.
REQ-003 SHALL derive localparam P as the smallest integer with 2^P >= DATA_W+P+1, and CODE_W = DATA_W+P, plus 1 when ECC_DED_EN is defined.
REQ-004 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_code valid.
REQ-007 SHALL have port in_ready  output  1  decoder accepts in_code this cycle.
REQ-008 SHALL have port in_code  input  CODE_W  received codeword.
REQ-009 SHALL have port out_valid  output  1  out_* fields valid.
REQ-010 SHALL have port out_ready  input  1  sink accepts output.
REQ-011 SHALL have port out_data  output  DATA_W  corrected data.
REQ-012 SHALL have port out_corrected  output  1  single-bit error was corrected.
REQ-013 SHALL have port out_uncorr  output  1  uncorrectable error; out_data is raw, uncorrected.
REQ-014 SHALL have port out_syndrome  output  P  Hamming syndrome of this word.
REQ-015 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-016 SHALL have port corr_cnt  output  CNT_W  corrected-error count.
REQ-017 SHALL have port uncorr_cnt  output  CNT_W  uncorrectable-error count.

Function
REQ-018 SHALL use this code layout: in_code[i] is Hamming position i+1; positions that are powers of two are check bits; data bit k is the k-th non-power-of-two position in ascending order.
REQ-019 SHALL compute syndrome bit j as the XOR of all in_code[i] where bit j of (i+1) is set.
REQ-020 SHALL treat syndrome s in 1..DATA_W+P as a single error at in_code[s-1], flip that bit, and assert out_corrected.
REQ-021 SHALL treat syndrome above DATA_W+P as uncorrectable: out_uncorr=1, no bit flipped, out_corrected=0.
REQ-022 SHALL never assert out_corrected and out_uncorr together; syndrome 0 SHALL give both flags 0.
REQ-023 SHALL be a 2-stage pipeline: stage 1 registers in_code and syndrome; stage 2 registers corrected data and flags; out_valid rises 2 cycles after an accepted input when not stalled.
REQ-024 SHALL advance both stages together when adv = !out_valid || out_ready; in_ready = adv (combinational from out_ready); a stage without valid data carries a bubble.
REQ-025 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-026 SHALL increment corr_cnt or uncorr_cnt by 1 on each output handshake (out_valid && out_ready) carrying the respective flag.
REQ-027 SHALL make both counters saturate at 2^CNT_W-1.
REQ-028 SHALL let clr_cnt take precedence: a counter cleared in the same cycle as an increment reads 0 the next cycle.

Reset
REQ-029 SHALL force, on rst_n low, both stage valids, out_valid, out_data, out_corrected, out_uncorr, out_syndrome, corr_cnt and uncorr_cnt to 0 immediately; in-flight words are discarded.
REQ-030 SHALL accept input on the first clk edge after rst_n deasserts, with in_ready=1.

Configuration
REQ-031 SHALL, when ECC_DED_EN is defined, treat in_code[CODE_W-1] as the overall even-parity bit over all other bits, with pm = XOR of all CODE_W bits.
REQ-032 SHALL, with ECC_DED_EN, decode as follows:
- pm=1 and s in range: correct.
- pm=1 and s=0: parity-bit error, corrected, data unchanged.
- pm=0 and s!=0: double error, uncorrectable.
- pm=1 and s out of range: uncorrectable.
REQ-033 SHALL, without ECC_DED_EN, decode by REQ-020/021 only (SEC; double errors may miscorrect).

Structure
REQ-034 SHALL place the P-derivation function, data/position mapping function and syndrome width constants in shared package ecc_pkg.
REQ-035 SHALL implement syndrome generation in combinational sub-module ecc_syndrome_calc, parameterised by DATA_W, reused by the encoder.

Verification (DATA_W=8, CODE_W=12 unless stated)
REQ-036 SHALL cover a clean word: in_code=0xA27 -> out_data=0xA5, syndrome 0, both flags 0, out_valid 2 cycles later.
REQ-037 SHALL cover a single error: in_code=0xA07 -> out_syndrome=6, out_data=0xA5, out_corrected=1, corr_cnt 0->1.
REQ-038 SHALL cover an out-of-range syndrome: in_code=0x226 -> syndrome 13, out_uncorr=1, uncorr_cnt increments, out_data raw.
REQ-039 SHALL cover a stall: out_ready=0 for 5 cycles with 3 words streamed -> in_ready drops, outputs held, no loss or duplication, counters count each word once.
REQ-040 SHALL cover counter edges: CNT_W=2 and 5 corrected words -> corr_cnt stays 3; clr_cnt with a simultaneous corrected handshake -> 0.
REQ-041 SHALL cover DED: with ECC_DED_EN, flip bits 0 and 1 of a clean code -> out_uncorr=1; rst_n pulse mid-stream -> out_valid=0 immediately.
